// File: rtl/quad_encoder_speed_sampler.sv
// Four-channel x4 quadrature decoder with per-window edge accumulation and a
// channel-serial valid/ready speed stream, snapshotted once per sample window.

module quad_lane #(
  parameter int   ACC_WIDTH  = 20,
  parameter int   DATA_WIDTH = 16,
  parameter logic INV        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a,
  input  logic                  b,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] win,
  output logic                  ill
);
  localparam logic signed [ACC_WIDTH:0]   SMAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0]   SMIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] DMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // [0],[1] form the synchroniser, [2] holds the previous synchronised state
  logic [2:0] a_sync, b_sync;
  logic [1:0] pos_cur, pos_prev, diff;
  logic signed [1:0] step;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] acc, acc_sat;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_sync <= '0;
      b_sync <= '0;
      acc    <= '0;
    end else begin
      a_sync <= {a_sync[1:0], a};
      b_sync <= {b_sync[1:0], b};
      acc    <= clr ? '0 : acc_sat;
    end

  // Gray code mapped to a position on the 4-state ring; the ring distance gives direction
  assign pos_cur  = {a_sync[1], a_sync[1] ^ b_sync[1]};
  assign pos_prev = {a_sync[2], a_sync[2] ^ b_sync[2]};
  assign diff     = pos_cur - pos_prev;
  assign ill      = (diff == 2'd2);

  always_comb begin
    step = 2'sb00;
    if (diff == 2'd1) step = INV ? 2'sb11 : 2'sb01;
    if (diff == 2'd3) step = INV ? 2'sb01 : 2'sb11;
  end

  assign sum = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH-1){step[1]}}, step};

  always_comb begin
    acc_sat = sum[ACC_WIDTH-1:0];
    if (sum > SMAX) acc_sat = SMAX[ACC_WIDTH-1:0];
    if (sum < SMIN) acc_sat = SMIN[ACC_WIDTH-1:0];
  end

  always_comb begin
    win = acc_sat[DATA_WIDTH-1:0];
    if (acc_sat > DMAX) win = DMAX[DATA_WIDTH-1:0];
    if (acc_sat < DMIN) win = DMIN[DATA_WIDTH-1:0];
  end
endmodule

module quad_encoder_speed_sampler #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         ACC_WIDTH   = 20,
  parameter int         CLK_FREQ    = 27_000_000,
  parameter int         SAMPLE_FREQ = 100,
  parameter logic [3:0] DIR_INV     = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [3:0]            enc_a,
  input  logic [3:0]            enc_b,
  input  logic                  y_ready,
  input  logic                  err_clr,
  output logic                  y_valid,
  output logic [2:0]            y_chn,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  tick,
  output logic [3:0]            enc_err,
  output logic                  overrun
);
  localparam int NUM_LANES  = 4;
  localparam int CHN_WIDTH  = 3;
  localparam int WINDOW     = CLK_FREQ / SAMPLE_FREQ;
  localparam int CNT_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;
  logic [1:0] chn, chn_nxt;
  logic       load;
  logic [CNT_W-1:0] cnt;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] win, snap;
  logic [NUM_LANES-1:0] ill;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    quad_lane #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .INV(DIR_INV[i])) u_lane (
      .clk (clk),
      .rstn(rstn),
      .a   (enc_a[i]),
      .b   (enc_b[i]),
      .clr (tick),
      .win (win[i]),
      .ill (ill[i])
    );
  end

  assign tick = (cnt == CNT_W'(WINDOW-1));

  always_comb begin
    state_nxt = state;
    chn_nxt   = chn;
    load      = 1'b0;
    case (state)
      IDLE: if (tick) begin
        load      = 1'b1;
        state_nxt = SEND;
        chn_nxt   = 2'd0;
      end
      SEND: if (y_ready) begin
        chn_nxt = chn + 2'd1;
        if (chn == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= IDLE;
      chn     <= '0;
      snap    <= '0;
      cnt     <= '0;
      enc_err <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      chn     <= chn_nxt;
      cnt     <= tick ? '0 : cnt + CNT_W'(1);
      if (load) snap <= win;
      // a new error event outranks a simultaneous clear
      enc_err <= (enc_err & ~{NUM_LANES{err_clr}}) | ill;
      overrun <= (overrun & ~err_clr) | (tick & (state == SEND));
    end

  assign y_valid = (state == SEND);
  assign y_chn   = CHN_WIDTH'(chn);
  assign y_data  = snap[chn];
endmodule
